// File: rtl/fetch_queue_pkg.sv
// Shared fetch-path definitions: the instruction memory window and the
// fetch address exception rule used when an entry is captured.
package fetch_queue_pkg;

  localparam logic [31:0] IM_BASE  = 32'h0000_3000;
  localparam logic [31:0] IM_LAST  = 32'h0000_6FFC;  // 4096 words
  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  // A fetch address faults when it is misaligned or outside the window.
  function automatic logic fetch_addr_exc(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_LAST);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Instruction fetch queue between the fetch unit and decode.
// Holds up to DEPTH {pc, instr, exc} entries in a circular buffer with
// valid/ready handshakes on both sides. in_ready depends only on registered
// occupancy, so a decode stall never reaches the PC path combinationally.
// A redirect flush discards every entry and rewinds both pointers to 0.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_pc4,
  output logic [31:0]              out_instr,
  output logic                     out_exc,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);  // 65: pc, instr, exc

  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE    = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      rd_ptr;
  logic [AW-1:0]      wr_ptr;
  entry_t             wr_entry;
  entry_t             head;
  logic               push;
  logic               pop;

  // Handshake status comes from registered occupancy only.
  assign in_ready  = (count != FULL_COUNT);
  assign out_valid = (count != '0);

  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  // Capture the incoming pair together with its fetch exception tag.
  always_comb begin
    wr_entry       = '0;
    wr_entry.pc    = in_pc;
    wr_entry.instr = in_instr;
    wr_entry.exc   = fetch_addr_exc(in_pc);
  end

  // Head entry is read straight from storage; stale when the queue is empty.
  always_comb begin
    head      = entry_t'(mem[rd_ptr]);
    out_pc    = head.pc;
    out_instr = head.instr;
    out_exc   = head.exc;
    out_pc4   = head.pc + 32'd4;
  end

  // Pointer, occupancy and storage update; flush outranks push and pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      // NOTE: storage is cleared on reset so the empty head reads as zero;
      // every entry is a plain flop with its own reset, not a memory macro.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      // NOTE: non-blocking assignments here let count, both pointers and the
      // written entry all update from the same pre-edge values.
      if (push) begin
        mem[wr_ptr] <= wr_entry;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push && !pop) begin
        count <= count + CNT_ONE;
      end else if (pop && !push) begin
        count <= count - CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a scoreboard queue models the
// expected contents, each scenario task drives stimulus and checks inline.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_pc4;
  logic [31:0] out_instr;
  logic        out_exc;
  logic        flush;
  logic [2:0]  count;

  exp_t        sb[$];
  int          tests_run;
  int          tests_failed;
  logic [31:0] last_pop_pc;
  logic        last_pop_exc;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_pc4   (out_pc4),
    .out_instr (out_instr),
    .out_exc   (out_exc),
    .flush     (flush),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent model of the fetch exception rule.
  function automatic logic model_exc(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc < 32'h0000_3000) || (pc > 32'h0000_6FFC);
  endfunction

  // Drive one cycle. Outputs are compared at the falling edge against the
  // scoreboard; the model then advances and the task returns 1 ns after the
  // rising edge.
  task automatic step(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                      input logic ordy, input logic fl);
    logic do_push;
    logic do_pop;
    exp_t e;
    exp_t n;
    in_valid  = iv;
    in_pc     = pc;
    in_instr  = ins;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    tests_run++;
    if (count !== 3'(sb.size())) begin
      tests_failed++;
      $display("FAIL step_count: got %0d expected %0d", count, sb.size());
    end
    tests_run++;
    if (in_ready !== (sb.size() != DEPTH)) begin
      tests_failed++;
      $display("FAIL step_in_ready: got %b expected %b", in_ready, sb.size() != DEPTH);
    end
    tests_run++;
    if (out_valid !== (sb.size() != 0)) begin
      tests_failed++;
      $display("FAIL step_out_valid: got %b expected %b", out_valid, sb.size() != 0);
    end
    do_push = iv && (sb.size() != DEPTH) && !fl;
    do_pop  = ordy && (sb.size() != 0) && !fl;
    if (do_pop) begin
      e = sb.pop_front();
      last_pop_pc  = out_pc;
      last_pop_exc = out_exc;
      tests_run++;
      if (out_pc !== e.pc || out_instr !== e.instr || out_exc !== e.exc ||
          out_pc4 !== e.pc + 32'd4) begin
        tests_failed++;
        $display("FAIL pop_entry: got pc=%h pc4=%h instr=%h exc=%b expected pc=%h pc4=%h instr=%h exc=%b",
                 out_pc, out_pc4, out_instr, out_exc, e.pc, e.pc + 32'd4, e.instr, e.exc);
      end
    end
    if (fl) begin
      sb.delete();
    end
    if (do_push) begin
      n.pc    = pc;
      n.instr = ins;
      n.exc   = model_exc(pc);
      sb.push_back(n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_drain();
    for (int i = 0; i < 2 * DEPTH && sb.size() != 0; i++) begin
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    end
    tests_run++;
    if (count !== 3'd0) begin
      tests_failed++;
      $display("FAIL drain_empty: got count=%0d expected 0", count);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    in_valid = 1'b0; in_pc = '0; in_instr = '0; out_ready = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || count !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_status: got out_valid=%b in_ready=%b count=%0d expected 0 1 0",
               out_valid, in_ready, count);
    end
    tests_run++;
    if (out_pc !== 32'h0 || out_pc4 !== 32'h4 || out_instr !== 32'h0 || out_exc !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_head: got pc=%h pc4=%h instr=%h exc=%b expected 0 4 0 0",
               out_pc, out_pc4, out_instr, out_exc);
    end
    reset = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    step(1'b1, 32'h0000_3000, 32'h3C01_0001, 1'b0, 1'b0);
    tests_run++;
    if (out_valid !== 1'b1 || out_pc !== 32'h3000 || out_pc4 !== 32'h3004 ||
        out_instr !== 32'h3C01_0001 || out_exc !== 1'b0 || count !== 3'd1) begin
      tests_failed++;
      $display("FAIL single_head: got v=%b pc=%h pc4=%h instr=%h exc=%b count=%0d expected 1 3000 3004 3c010001 0 1",
               out_valid, out_pc, out_pc4, out_instr, out_exc, count);
    end
    idle_drain();
  endtask

  task automatic test_full();
    bit accepted;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 32'h3000 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b0, 1'b0);
      if (i == 3) begin
        tests_run++;
        if (in_ready !== 1'b0 || count !== 3'd4) begin
          tests_failed++;
          $display("FAIL full_after_4: got in_ready=%b count=%0d expected 0 4", in_ready, count);
        end
      end
    end
    tests_run++;
    if (count !== 3'd4 || out_pc !== 32'h3000) begin
      tests_failed++;
      $display("FAIL full_5th_rejected: got count=%0d head=%h expected 4 3000", count, out_pc);
    end
    // Fetch holds the 5th entry until the queue has room.
    accepted = 1'b0;
    for (int k = 0; k < 8 && !accepted; k++) begin
      accepted = (sb.size() != DEPTH);
      step(1'b1, 32'h3010, 32'hA000_0004, 1'b1, 1'b0);
    end
    tests_run++;
    if (!accepted) begin
      tests_failed++;
      $display("FAIL full_5th_accept: got accepted=0 expected 1");
    end
    idle_drain();
    tests_run++;
    if (last_pop_pc !== 32'h3010) begin
      tests_failed++;
      $display("FAIL full_last_pop: got %h expected 00003010", last_pop_pc);
    end
  endtask

  task automatic test_back_to_back();
    step(1'b1, 32'h3000, 32'hB000_0000, 1'b0, 1'b0);
    step(1'b1, 32'h3004, 32'hB000_0001, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'h3008 + 32'(4 * i), 32'hB000_0002 + 32'(i), 1'b1, 1'b0);
      tests_run++;
      if (count !== 3'd2 || last_pop_pc !== 32'h3000 + 32'(4 * i)) begin
        tests_failed++;
        $display("FAIL b2b_cycle%0d: got count=%0d popped=%h expected 2 %h",
                 i, count, last_pop_pc, 32'h3000 + 32'(4 * i));
      end
    end
    idle_drain();
  endtask

  task automatic test_exc();
    logic [31:0] pcs  [4];
    logic        excs [4];
    pcs[0] = 32'h3002; excs[0] = 1'b1;
    pcs[1] = 32'h2FFC; excs[1] = 1'b1;
    pcs[2] = 32'h6FFC; excs[2] = 1'b0;
    pcs[3] = 32'h7000; excs[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, pcs[i], 32'hC000_0000 + 32'(i), 1'b0, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      tests_run++;
      if (last_pop_pc !== pcs[i] || last_pop_exc !== excs[i]) begin
        tests_failed++;
        $display("FAIL exc_%h: got pc=%h exc=%b expected exc=%b",
                 pcs[i], last_pop_pc, last_pop_exc, excs[i]);
      end
    end
    idle_drain();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h3020 + 32'(4 * i), 32'hD000_0000 + 32'(i), 1'b0, 1'b0);
    end
    last_pop_pc = 32'hFFFF_FFFF;
    step(1'b1, 32'h3100, 32'hD000_00FF, 1'b1, 1'b1);
    tests_run++;
    if (count !== 3'd0 || out_valid !== 1'b0 || last_pop_pc !== 32'hFFFF_FFFF) begin
      tests_failed++;
      $display("FAIL flush_empty: got count=%0d out_valid=%b popped=%h expected 0 0 none",
               count, out_valid, last_pop_pc);
    end
    step(1'b1, 32'h3040, 32'hD000_0040, 1'b0, 1'b0);
    tests_run++;
    if (count !== 3'd1 || out_valid !== 1'b1 || out_pc !== 32'h3040) begin
      tests_failed++;
      $display("FAIL flush_next_push: got count=%0d out_valid=%b pc=%h expected 1 1 3040",
               count, out_valid, out_pc);
    end
    idle_drain();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h3200 + 32'(4 * i), 32'hE000_0000 + 32'(i), 1'b0, 1'b0);
    end
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || count !== 3'd0 || out_pc !== 32'h0) begin
      tests_failed++;
      $display("FAIL async_reset: got out_valid=%b in_ready=%b count=%0d pc=%h expected 0 1 0 0",
               out_valid, in_ready, count, out_pc);
    end
    sb.delete();
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 32'h3300, 32'hE000_0100, 1'b0, 1'b0);
    tests_run++;
    if (count !== 3'd1 || out_pc !== 32'h3300) begin
      tests_failed++;
      $display("FAIL after_reset_push: got count=%0d pc=%h expected 1 3300", count, out_pc);
    end
    idle_drain();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    last_pop_pc  = '0;
    last_pop_exc = 1'b0;
    test_reset();
    test_single();
    test_full();
    test_back_to_back();
    test_exc();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
